bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, width of all byte addresses.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles per beat for mem_ack before abort.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch request; always a word read.
REQ-006 if_addr  input  ADDR_W  fetch byte address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_err  output  1  fetch error, valid only with if_ack.
REQ-009 if_rdata  output  32  fetched word, valid only with if_ack.
REQ-010 d_req  input  1  data load/store request.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-013 d_addr  input  ADDR_W  data byte address.
REQ-014 d_wdata  input  32  store data, right-aligned.
REQ-015 d_ack  output  1  one-cycle data completion pulse.
REQ-016 d_err  output  1  data error, valid only with d_ack.
REQ-017 d_rdata  output  32  load data, right-aligned, upper unused bytes zero.
REQ-018 mem_req  output  1  external byte-bus beat request.
REQ-019 mem_we  output  1  beat is a write.
REQ-020 mem_addr  output  ADDR_W  beat byte address.
REQ-021 mem_wdata  output  8  beat write byte.
REQ-022 mem_rdata  input  8  beat read byte, sampled when mem_ack is high.
REQ-023 mem_ack  input  1  beat complete, sampled on the clock edge.

Function
REQ-024 FSM states: IDLE, XFER, RESP. Transitions: IDLE->XFER on grant; IDLE->RESP on misaligned/illegal grant; XFER->RESP after the last beat or on timeout; RESP->IDLE always.
REQ-025 Requester protocol: req held high with stable fields until its ack pulse; req high in RESP is not a new request; the arbiter completes a transfer even if req drops.
REQ-026 Arbitration in IDLE: single pending request granted; if both pending, grant the port not granted last (round-robin); last-grant pointer resets to data, so fetch wins the first tie.
REQ-027 Beat count B: byte 1, half 2, word 4; beat i uses mem_addr = base+i, little-endian (byte i = bits 8i+7:8i).
REQ-028 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or d_size=11 -> no mem_req, err=1 with ack in the next cycle.
REQ-029 In XFER, mem_req stays high, with mem_we/mem_addr/mem_wdata stable, until mem_ack; the beat advances on the mem_ack edge.
REQ-030 Latency with zero-wait memory: request sampled in IDLE cycle k -> ack high in cycle k+1+B; each memory wait cycle adds one.
REQ-031 Per-beat wait counter clears on each beat start; after TIMEOUT cycles without mem_ack, abort to RESP with err=1 and rdata=0, with no further beats.
REQ-032 mem_req is 0 in IDLE and RESP; mem_we=0 on all fetch beats.
REQ-033 rdata is held until the next ack of the same port; ack/err are low outside RESP; at most one of if_ack and d_ack is high per cycle.

Reset
REQ-034 While rst_n is low at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack/d_ack/if_err/d_err=0, rdata=0, beat and wait counters=0, last-grant=data.
REQ-035 Reset asserted mid-transfer abandons it with no ack; requesters re-issue.

Structure
REQ-036 Shared package riscyjr_pkg holds the d_size encodings, FSM state enum, and TIMEOUT default.
REQ-037 Single module; no sub-module.

Verification
REQ-038 Fetch only, if_addr=0x0100, zero-wait memory returning bytes 11,22,33,44 -> 4 beats at 0x0100-0x0103, if_rdata=0x44332211, if_ack at k+5.
REQ-039 Store half d_wdata=0xBEEF to 0x0202 -> beats (0x0202,EF),(0x0203,BE) with mem_we=1, d_ack at k+3, d_err=0.
REQ-040 if_req and d_req high together, repeated -> first grant fetch, then grants alternate data/fetch.
REQ-041 Load word at 0x0005 -> no mem_req, d_ack with d_err=1 in the next cycle.
REQ-042 mem_ack held low -> mem_req high for exactly 15 cycles, then ack with err=1 and rdata=0.
REQ-043 rst_n low during beat 2 of a word read -> next cycle mem_req=0, IDLE, no ack ever issued.

Source files
------------

// File: rtl/riscyjr_pkg.sv
// Shared encodings and helpers for the riscyjr byte-bus arbiter.
package riscyjr_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEF = 15;

    // Half needs addr[0]=0, word needs addr[1:0]=0; the reserved size is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size_e'(size))
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lsb[0];
            SIZE_WORD: return (lsb != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] last_beat_idx(input logic [1:0] size);
        case (size_e'(size))
            SIZE_BYTE: return 2'd0;
            SIZE_HALF: return 2'd1;
            default:   return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that serialises fetch and data requests onto an 8-bit memory bus.
module bus_arbiter
    import riscyjr_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state;
    logic              last_data;
    logic              cur_data;
    logic              cur_we;
    logic [1:0]        beat;
    logic [1:0]        last_beat;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wbuf;
    logic [31:0]       rbuf;
    logic [WAIT_W-1:0] wait_cnt;

    logic        grant_if_c;
    logic        grant_d_c;
    logic        d_bad_c;
    logic [1:0]  beat_next_c;
    logic [31:0] rbuf_next_c;
    logic [7:0]  wbyte_next_c;

    // Fetch wins a tie only when data held the previous grant.
    always_comb begin
        grant_if_c   = if_req && (!d_req || last_data);
        grant_d_c    = d_req && !grant_if_c;
        d_bad_c      = is_misaligned(d_size, d_addr[1:0]);
        beat_next_c  = beat + 2'd1;
        rbuf_next_c  = rbuf | (32'(mem_rdata) << {beat, 3'b000});
        wbyte_next_c = wbuf[{beat_next_c, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            last_data <= 1'b1;
            cur_data  <= 1'b0;
            cur_we    <= 1'b0;
            beat      <= 2'd0;
            last_beat <= 2'd0;
            base      <= '0;
            wbuf      <= '0;
            rbuf      <= '0;
            wait_cnt  <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ack <= 1'b0;
            if_err <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    beat     <= 2'd0;
                    wait_cnt <= '0;
                    rbuf     <= '0;
                    if (grant_if_c) begin
                        last_data <= 1'b0;
                        cur_data  <= 1'b0;
                        cur_we    <= 1'b0;
                        base      <= if_addr;
                        wbuf      <= '0;
                        last_beat <= 2'd3;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 8'h00;
                        state     <= ST_XFER;
                    end else if (grant_d_c) begin
                        last_data <= 1'b1;
                        cur_data  <= 1'b1;
                        cur_we    <= d_we;
                        base      <= d_addr;
                        wbuf      <= d_wdata;
                        last_beat <= last_beat_idx(d_size);
                        if (d_bad_c) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                            state   <= ST_RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata[7:0];
                            state     <= ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (mem_ack) begin
                        rbuf     <= rbuf_next_c;
                        wait_cnt <= '0;
                        if (beat == last_beat) begin
                            mem_req <= 1'b0;
                            state   <= ST_RESP;
                            if (cur_data) begin
                                d_ack   <= 1'b1;
                                d_rdata <= cur_we ? 32'h0 : rbuf_next_c;
                            end else begin
                                if_ack   <= 1'b1;
                                if_rdata <= rbuf_next_c;
                            end
                        end else begin
                            beat      <= beat_next_c;
                            mem_addr  <= base + ADDR_W'(beat_next_c);
                            mem_wdata <= wbyte_next_c;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abort: the whole transfer fails, not just the stalled beat.
                        mem_req <= 1'b0;
                        state   <= ST_RESP;
                        if (cur_data) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_err   <= 1'b1;
                            if_rdata <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a zero-wait byte memory model.
module tb_bus_arbiter;

    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_err;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [31:0]       d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic              ack_en;

    logic [7:0] mem [0:1023];

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } beat_t;

    beat_t blog[$];
    int    req_cycles = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    assign mem_ack   = mem_req & ack_en;
    assign mem_rdata = mem[mem_addr[9:0]];

    bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always @(posedge clk) begin
        if (rst_n && mem_req) begin
            req_cycles <= req_cycles + 1;
            if (mem_ack) blog.push_back({mem_we, mem_addr, mem_wdata});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns cycles from the current sample point to the first ack sample.
    task automatic wait_ack(output int lat, output logic which_d);
        logic seen;
        seen    = 1'b0;
        lat     = 0;
        which_d = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (if_ack || d_ack) begin
                seen    = 1'b1;
                which_d = d_ack;
                check("ack_onehot", 64'(if_ack && d_ack), 64'd0);
            end
        end
        if (!seen) check("ack_timeout", 64'd0, 64'd1);
    endtask

    int   lat;
    logic wd;
    int   b0;
    int   rc0;
    int   acks;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        mem[10'h200] = 8'h01; mem[10'h201] = 8'h02; mem[10'h202] = 8'h03; mem[10'h203] = 8'h04;
        rst_n = 1'b0; ack_en = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_acks", 64'({if_ack, d_ack, if_err, d_err}), 64'd0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        rst_n = 1'b1;

        // Tie: fetch first after reset, then strict alternation.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0200;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 16'h0100;
        for (int i = 0; i < 4; i++) begin
            wait_ack(lat, wd);
            check($sformatf("tie_order_%0d", i), 64'(wd), 64'(i % 2));
            if (wd) check("tie_d_rdata", 64'(d_rdata), 64'h44332211);
            else    check("tie_if_rdata", 64'(if_rdata), 64'h04030201);
        end
        if_req = 1'b0; d_req = 1'b0;

        // Fetch word at 0x0100.
        @(posedge clk); #1;
        b0 = blog.size();
        if_req = 1'b1; if_addr = 16'h0100;
        wait_ack(lat, wd);
        if_req = 1'b0;
        check("fetch_lat", 64'(lat), 64'd5);
        check("fetch_port", 64'(wd), 64'd0);
        check("fetch_err", 64'(if_err), 64'd0);
        check("fetch_rdata", 64'(if_rdata), 64'h44332211);
        check("fetch_nbeats", 64'(blog.size() - b0), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("fetch_beat_%0d", i), 64'({blog[b0+i].we, blog[b0+i].addr}),
                  64'({1'b0, 16'h0100 + 16'(i)}));

        // Store half 0xBEEF to 0x0202.
        @(posedge clk); #1;
        b0 = blog.size();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 16'h0202; d_wdata = 32'h0000BEEF;
        wait_ack(lat, wd);
        d_req = 1'b0;
        check("sh_lat", 64'(lat), 64'd3);
        check("sh_port", 64'(wd), 64'd1);
        check("sh_err", 64'(d_err), 64'd0);
        check("sh_nbeats", 64'(blog.size() - b0), 64'd2);
        check("sh_beat0", 64'(blog[b0]), 64'({1'b1, 16'h0202, 8'hEF}));
        check("sh_beat1", 64'(blog[b0+1]), 64'({1'b1, 16'h0203, 8'hBE}));
        check("sh_if_rdata_held", 64'(if_rdata), 64'h44332211);

        // Load byte from 0x0203: upper bytes zero.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 16'h0203;
        wait_ack(lat, wd);
        d_req = 1'b0;
        check("lb_lat", 64'(lat), 64'd2);
        check("lb_rdata", 64'(d_rdata), 64'h00000004);

        // Misaligned word, misaligned half, illegal size: error next cycle, no bus traffic.
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            rc0 = req_cycles;
            d_req = 1'b1; d_we = 1'b0;
            d_size = (t == 0) ? 2'b10 : (t == 1) ? 2'b01 : 2'b11;
            d_addr = (t == 0) ? 16'h0005 : (t == 1) ? 16'h0201 : 16'h0000;
            wait_ack(lat, wd);
            d_req = 1'b0;
            check($sformatf("mis%0d_lat", t), 64'(lat), 64'd1);
            check($sformatf("mis%0d_err", t), 64'({wd, d_err}), 64'b11);
            check($sformatf("mis%0d_rdata", t), 64'(d_rdata), 64'd0);
            check($sformatf("mis%0d_noreq", t), 64'(req_cycles - rc0), 64'd0);
        end

        // Timeout on a stalled memory.
        @(posedge clk); #1;
        ack_en = 1'b0;
        rc0 = req_cycles;
        if_req = 1'b1; if_addr = 16'h0100;
        wait_ack(lat, wd);
        if_req = 1'b0;
        check("to_req_cycles", 64'(req_cycles - rc0), 64'd15);
        check("to_err", 64'({wd, if_err}), 64'b01);
        check("to_rdata", 64'(if_rdata), 64'd0);
        ack_en = 1'b1;

        // Reset during beat 2 of a word fetch.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0100;
        for (int i = 0; i < 10 && !(mem_req && mem_addr == 16'h0102); i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_reached", 64'(mem_req && mem_addr == 16'h0102), 64'd1);
        rst_n = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        check("rst_mid_mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (if_ack || d_ack) acks++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_ack", 64'(acks), 64'd0);

        // Last-grant pointer is back to data: fetch wins the tie.
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 16'h0200;
        wait_ack(lat, wd);
        if_req = 1'b0; d_req = 1'b0;
        check("post_rst_tie", 64'(wd), 64'd0);
        check("post_rst_lat", 64'(lat), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
